// File: rtl/countdown_display.sv
// Three-digit multiplexed 7-segment driver for a BCD countdown, with leading-zero blanking and expiry blink.
// Latency: seg/an change one cycle after a slot tick; value inputs take effect at the next frame wrap.
// Backpressure: none; it free-runs on its prescaler and always accepts the current inputs.
module countdown_display #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value_one,
  input  logic [3:0] value_two,
  input  logic [3:0] value_three,
  input  logic       expired,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic {BLINK_ON = 1'b0, BLINK_OFF = 1'b1} blink_t;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0]    sh_one, sh_two, sh_three;
  logic [FW-1:0] frame_cnt;
  blink_t        state;

  logic          tick, wrap;
  logic [1:0]    idx_n;
  logic [3:0]    sh_one_n, sh_two_n, sh_three_n;
  logic [FW-1:0] frame_cnt_n;
  blink_t        state_n;
  logic [3:0]    digit_n;
  logic          blank_n;
  logic [6:0]    seg_n;
  logic [2:0]    an_n;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign tick = (presc == PRESC_MAX);
  assign wrap = tick && (idx == 2'd2);

  // Next-state view so seg/an land in the cycle right after a tick, with the freshly captured digits.
  always_comb begin
    idx_n = idx;
    if (tick) idx_n = (idx == 2'd2) ? 2'd0 : idx + 2'd1;

    sh_one_n   = sh_one;
    sh_two_n   = sh_two;
    sh_three_n = sh_three;
    if (wrap) begin
      sh_one_n   = value_one;
      sh_two_n   = value_two;
      sh_three_n = value_three;
    end

    // Frames are counted at the wrap that also raises frame_done, so blink phases align to frame starts.
    state_n     = state;
    frame_cnt_n = frame_cnt;
    if (!expired) begin
      state_n     = BLINK_ON;
      frame_cnt_n = '0;
    end else if (wrap) begin
      if (frame_cnt == FRAME_MAX) begin
        frame_cnt_n = '0;
        state_n     = (state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        frame_cnt_n = frame_cnt + 1'b1;
      end
    end

    case (idx_n)
      2'd1:    digit_n = sh_two_n;
      2'd2:    digit_n = sh_three_n;
      default: digit_n = sh_one_n;
    endcase

    blank_n = blank_lz &&
              (((idx_n == 2'd2) && (sh_three_n == 4'd0)) ||
               ((idx_n == 2'd1) && (sh_three_n == 4'd0) && (sh_two_n == 4'd0)));

    seg_n = blank_n ? SEG_OFF : decode(digit_n);
    an_n  = ~(3'b001 << idx_n);
    if (state_n == BLINK_OFF) begin
      seg_n = SEG_OFF;
      an_n  = 3'b111;
    end
  end

  // Scan datapath: prescaler, digit index, shadow capture and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc      <= '0;
      idx        <= 2'd0;
      sh_one     <= 4'd0;
      sh_two     <= 4'd0;
      sh_three   <= 4'd0;
      seg        <= SEG_OFF;
      an         <= 3'b111;
      frame_done <= 1'b0;
    end else begin
      presc      <= tick ? '0 : presc + 1'b1;
      idx        <= idx_n;
      sh_one     <= sh_one_n;
      sh_two     <= sh_two_n;
      sh_three   <= sh_three_n;
      seg        <= seg_n;
      an         <= an_n;
      frame_done <= wrap;
    end
  end

  // Blink FSM and its frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= BLINK_ON;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_cnt_n;
    end
  end

endmodule

// File: doc/countdown_display.md
COUNTDOWN_DISPLAY -- requirements
Module: countdown_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clk cycles per digit slot (>=2).
REQ-002 Parameter BLINK_FRAMES, default 100: full scan frames per blink half-period (>=1).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; reset==0 forces reset state immediately.
REQ-005 value_one  in  4  BCD units digit from the countdown.
REQ-006 value_two  in  4  BCD tens digit.
REQ-007 value_three  in  4  BCD hundreds digit.
REQ-008 expired  in  1  level; 1 = timer expired, display blinks.
REQ-009 blank_lz  in  1  level; 1 = leading-zero blanking enabled.
REQ-010 seg  out  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-011 an  out  3  active-low one-hot digit enables, an[0]=one, an[1]=two, an[2]=three, registered.
REQ-012 frame_done  out  1  one-cycle pulse at end of each full scan frame, registered.

Function
REQ-013 Prescaler counts 0..REFRESH_DIV-1 and wraps to 0; slot tick asserted in the cycle the count equals REFRESH_DIV-1.
REQ-014 Scan index 0->1->2->0 advances only on slot tick; index 0 selects value_one, 1 value_two, 2 value_three.
REQ-015 frame_done pulses high for exactly one cycle, the cycle after a tick that wraps the index 2->0.
REQ-016 On each 2->0 wrap tick, all three value inputs are captured into shadow registers; display uses only shadow values (no tearing mid-frame).
REQ-017 seg/an update one cycle after slot tick to reflect the new index; stable between ticks.
REQ-018 Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 Non-BCD digit (10..15) shows dash, seg=0111111.
REQ-020 blank_lz=1: digit three blank (seg=1111111) when shadow three==0; digit two blank when shadow three==0 and shadow two==0; digit one never blanked.
REQ-021 Blanked digit still drives its an bit low (slot timing unchanged).
REQ-022 Blink FSM states ON, OFF; in ON an follows scan, in OFF an=111 and seg=1111111.
REQ-023 While expired=1, frame counter increments per frame_done; at BLINK_FRAMES frames it clears and FSM toggles ON<->OFF.
REQ-024 expired=0 forces FSM to ON and clears frame counter on the next clock edge, regardless of current phase.
REQ-025 expired rising mid-frame: counting starts from the next frame_done; first OFF phase begins after BLINK_FRAMES complete frames.
REQ-026 Input changes between wraps have no visible effect until the next capture.

Reset
REQ-027 During reset==0: an=111, seg=1111111, frame_done=0, prescaler=0, index=0, shadow digits=0, frame counter=0, FSM=ON.
REQ-028 Reset asserted mid-frame or mid-blink aborts immediately to REQ-027 state; first slot tick occurs REFRESH_DIV cycles after release.
REQ-029 Until the first 2->0 capture after reset, displayed digits are shadow zeros.

Verification (REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-030 Release reset, values 1/2/3 (three/two/one), blank_lz=0 -> after first capture, successive slots: an=110 seg=0110000, an=101 seg=0100100, an=011 seg=1111001; each slot 4 cycles; frame_done every 12 cycles.
REQ-031 Values 0/0/7, blank_lz=1 -> digit one 1111000, digits two and three seg=1111111 with an still strobed; blank_lz=0 -> both show 1000000.
REQ-032 value_one=4'hC -> digit one seg=0111111.
REQ-033 Change value_two 5->8 mid-frame -> old 5 persists until next frame_done, 8 shown in following frame.
REQ-034 expired=1 -> 2 frames ON, 2 frames an=111, repeat; drop expired during OFF -> an resumes scanning next cycle.
REQ-035 Assert reset mid-slot during OFF phase -> an=111, seg=1111111, frame_done=0 asynchronously; after release FSM ON, shadow zeros displayed.
